// File: rtl/blink_dec_pkg.sv
// Shared constants, state encoding and decimal-split helpers for the blink rate decoder.
package blink_dec_pkg;

  localparam logic [4:0] RATE_MAX  = 5'd31;
  localparam logic [3:0] POS_UNITS = 4'b0001;
  localparam logic [3:0] POS_TENS  = 4'b0010;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

  typedef enum logic {IDLE, GATE} state_e;

  function automatic logic [3:0] tens_of(input logic [4:0] v);
    if (v >= 5'd30)      return 4'd3;
    else if (v >= 5'd20) return 4'd2;
    else if (v >= 5'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] units_of(input logic [4:0] v);
    if (v >= 5'd30)      return 4'(v - 5'd30);
    else if (v >= 5'd20) return 4'(v - 5'd20);
    else if (v >= 5'd10) return 4'(v - 5'd10);
    else                 return 4'(v);
  endfunction

endpackage

// File: rtl/blink_rate_decoder_seg_digit_enc.sv
// Combinational BCD digit to seven-segment pattern; non-decimal codes go dark.
module seg_digit_enc
  import blink_dec_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = 8'h00;
    endcase
  end

endmodule

// File: rtl/blink_rate_decoder.sv
// Debounces a blink signal, counts its rising edges per gate window and shows
// the recovered rate on a two-digit scanned seven-segment display.
module blink_rate_decoder
  import blink_dec_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int FILT_CYCLES = 500_000,
  parameter int SCAN_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_in,
  output logic [4:0] rate_val,
  output logic       rate_vld,
  output logic       stable,
  output logic       lost,
  output logic [3:0] pos,
  output logic [7:0] seg
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic          sig_s1_q, sig_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  state_e        state_q, state_d;
  logic [GW-1:0] gate_cnt_q, gate_cnt_d;
  logic [5:0]    edge_cnt_q, edge_cnt_d;
  logic [4:0]    rate_q, rate_d, prev_q, prev_d;
  logic          vld_q, vld_d, stable_q, stable_d, lost_q, lost_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [3:0]    pos_q, pos_d;
  logic [7:0]    seg_q, seg_d;

  logic       rise;
  logic [5:0] edge_inc;
  logic [4:0] win_sat;
  logic [3:0] enc_digit;
  logic [7:0] enc_seg;

  // Level filter: a new level must persist FILT_CYCLES cycles; any relapse restarts the count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (sig_s2_q != filt_q) begin
      if (filt_cnt_q == FW'(FILT_CYCLES - 1)) begin
        filt_d = sig_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign rise     = filt_d & ~filt_q;
  assign edge_inc = (edge_cnt_q == 6'd63) ? 6'd63 : edge_cnt_q + {5'd0, rise};
  assign win_sat  = (edge_inc > {1'b0, RATE_MAX}) ? RATE_MAX : edge_inc[4:0];

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    rate_d     = rate_q;
    prev_d     = prev_q;
    stable_d   = stable_q;
    lost_d     = lost_q;
    vld_d      = 1'b0;
    case (state_q)
      IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        state_d    = GATE;
      end
      GATE: begin
        if (gate_cnt_q == GW'(GATE_CYCLES - 1)) begin
          // An edge landing in the terminal cycle belongs to the window closing now.
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          rate_d     = win_sat;
          lost_d     = (edge_inc == 6'd0);
          stable_d   = (win_sat == prev_q);
          prev_d     = win_sat;
          vld_d      = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          edge_cnt_d = edge_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Display latches the digit for the position it is switching to, so pos and seg move together.
  assign enc_digit = (pos_q == POS_UNITS) ? tens_of(rate_q) : units_of(rate_q);

  seg_digit_enc u_enc (
    .digit (enc_digit),
    .seg   (enc_seg)
  );

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    pos_d      = pos_q;
    seg_d      = seg_q;
    if (scan_cnt_q == SW'(SCAN_CYCLES - 1)) begin
      scan_cnt_d = '0;
      pos_d      = (pos_q == POS_UNITS) ? POS_TENS : POS_UNITS;
      seg_d      = enc_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_s1_q   <= 1'b0;
      sig_s2_q   <= 1'b0;
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      rate_q     <= '0;
      prev_q     <= '0;
      vld_q      <= 1'b0;
      stable_q   <= 1'b0;
      lost_q     <= 1'b0;
      scan_cnt_q <= '0;
      pos_q      <= POS_UNITS;
      seg_q      <= SEG_0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sig_s1_q   <= sig_in;
      sig_s2_q   <= sig_s1_q;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      rate_q     <= rate_d;
      prev_q     <= prev_d;
      vld_q      <= vld_d;
      stable_q   <= stable_d;
      lost_q     <= lost_d;
      scan_cnt_q <= scan_cnt_d;
      pos_q      <= pos_d;
      seg_q      <= seg_d;
    end
  end

  assign rate_val = rate_q;
  assign rate_vld = vld_q;
  assign stable   = stable_q;
  assign lost     = lost_q;
  assign pos      = pos_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Scoreboard bench: stimulus queues expected window results, a monitor checks each rate_vld.
module tb_blink_rate_decoder;

  localparam int GATE = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig_in = 1'b0;
  logic [4:0] rate_val;
  logic       rate_vld, stable, lost;
  logic [3:0] pos;
  logic [7:0] seg;

  blink_rate_decoder #(.GATE_CYCLES(GATE), .FILT_CYCLES(4), .SCAN_CYCLES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .rate_val (rate_val),
    .rate_vld (rate_vld),
    .stable   (stable),
    .lost     (lost),
    .pos      (pos),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         exp_n;
    logic [4:0] rate;
    bit         chk_rate;
    logic       lost;
    bit         chk_lost;
    logic       stable;
    bit         chk_stable;
  } win_t;

  win_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  // cyc = posedges since reset release; DUT cycle number n = cyc + 1 (cycle 1 is IDLE).
  int cyc = 0;
  int period = 0, period2 = 0, switch_g = 1 << 30;
  bit glitch = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Absolute gate index g: rising edge on sig_in when g%p==0 is counted at gate index g.
  function automatic logic wave(input int g);
    int p, m;
    p = (g >= switch_g) ? period2 : period;
    if (p == 0) return 1'b0;
    m = g % p;
    return (m < p / 2) || (glitch && (m == 70 || m == 71));
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst_n) cyc = 0;
    else        cyc++;
  end

  initial forever begin
    @(negedge clk);
    sig_in = rst_n ? wave(cyc + 4) : 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && rate_vld) begin
      if (sb_q.size() == 0) begin
        check("unexpected_vld", 1, 0);
      end else begin
        win_t e;
        e = sb_q.pop_front();
        check("vld_cycle", cyc + 1, e.exp_n);
        if (e.chk_rate)   check("rate_val", int'(rate_val), int'(e.rate));
        if (e.chk_lost)   check("lost", int'(lost), int'(e.lost));
        if (e.chk_stable) check("stable", int'(stable), int'(e.stable));
      end
    end
  end

  task automatic push(input int k, input int rate, input bit cr, input logic ls, input bit cl,
                      input logic st, input bit cs);
    win_t e;
    e.exp_n = 1002 + GATE * k;
    e.rate = 5'(rate); e.chk_rate = cr;
    e.lost = ls;       e.chk_lost = cl;
    e.stable = st;     e.chk_stable = cs;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rate"}, int'(rate_val), 0);
    check({tag, "_vld"}, int'(rate_vld), 0);
    check({tag, "_stable"}, int'(stable), 0);
    check({tag, "_lost"}, int'(lost), 0);
    check({tag, "_pos"}, int'(pos), 1);
    check({tag, "_seg"}, int'(seg), 8'h3F);
  endtask

  task automatic start(input int p, input int p2, input int sw, input bit gl);
    @(negedge clk);
    rst_n = 1'b0;
    period = p; period2 = p2; switch_g = sw; glitch = gl;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_digit(input logic [3:0] want_pos, input int want_seg, input string name);
    for (int i = 0; i < 40 && pos != want_pos; i++) @(negedge clk);
    check({name, "_pos"}, int'(pos), int'(want_pos));
    check({name, "_seg"}, int'(seg), want_seg);
  endtask

  task automatic finish_scn(input int last_k, input int units, input int tens);
    wait_cyc(1001 + GATE * last_k + 30);
    check_digit(4'b0001, units, "units");
    check_digit(4'b0010, tens, "tens");
    check("sb_drain", sb_q.size(), 0);
  endtask

  initial begin
    // 1: period 100 -> 10 Hz
    start(100, 100, 1 << 30, 0);
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, 10, 1, 0, 1, 1, 1);
    push(2, 10, 1, 0, 1, 1, 1);
    finish_scn(2, 8'h3F, 8'h06);

    // 2: input held low
    start(0, 0, 1 << 30, 0);
    push(0, 0, 1, 1, 1, 0, 0);
    push(1, 0, 1, 1, 1, 1, 1);
    push(2, 0, 1, 1, 1, 1, 1);
    finish_scn(2, 8'h3F, 8'h3F);

    // 3: period 100 with 2-cycle glitches in the low phase
    start(100, 100, 1 << 30, 1);
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, 10, 1, 0, 1, 1, 1);
    push(2, 10, 1, 0, 1, 1, 1);
    finish_scn(2, 8'h3F, 8'h06);

    // 4: period 20 -> 50 edges, saturates at 31
    start(20, 20, 1 << 30, 0);
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, 31, 1, 0, 1, 1, 1);
    push(2, 31, 1, 0, 1, 1, 1);
    finish_scn(2, 8'h06, 8'h4F);

    // 5: period 100 -> 50 at the start of window 2
    start(100, 50, 2 * GATE, 0);
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, 10, 1, 0, 1, 1, 1);
    push(2, 20, 1, 0, 1, 0, 1);
    push(3, 20, 1, 0, 1, 1, 1);
    finish_scn(3, 8'h3F, 8'h5B);

    // 6: reset at gate counter 500 of window 1, then restart timing
    start(100, 100, 1 << 30, 0);
    push(0, 10, 1, 0, 1, 0, 0);
    wait_cyc(1501);
    check("pre_reset_rate", int'(rate_val), 10);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    check("midreset_drain", sb_q.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(0, 10, 1, 0, 1, 0, 0);
    push(1, 10, 1, 0, 1, 1, 1);
    finish_scn(1, 8'h3F, 8'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blink_rate_decoder.md
# blink_rate_decoder

Receive-side counterpart of the alarm blinker. It takes a blinking LED-style signal, such as the alarm output of the button/counter block, and debounces it. It measures the blink frequency by counting filtered rising edges over a fixed gate window, and recovers the rate value (0–31). That value is shown as two decimal digits on the scanned seven-segment display.

## Interface
Parameters:
- GATE_CYCLES, 50_000_000: gate window length in clk cycles (1 s at 50 MHz); count per window = rate in Hz.
- FILT_CYCLES, 500_000: cycles a new input level must persist before it is accepted (10 ms).
- SCAN_CYCLES, 50_000: clk cycles per display digit before switching to the other digit.

Ports:
- clk  input  1  system clock, single clock domain
- rst_n  input  1  reset; asynchronous, active-low
- sig_in  input  1  blink signal, asynchronous to clk
- rate_val  output  5  decoded rate of the last completed window, saturated at 31
- rate_vld  output  1  one-cycle pulse when rate_val updates
- stable  output  1  high while the last two completed windows gave equal counts
- lost  output  1  high when the last completed window saw zero edges
- pos  output  4  digit select, one-hot: 4'b0001 units, 4'b0010 tens
- seg  output  8  segment pattern {dp,g,f,e,d,c,b,a}, active-high

## Operation
- **Input path:** 2-flop synchronizer, then level filter.
  - The filtered level changes only after the synchronized input differs from it for FILT_CYCLES consecutive cycles.
  - Shorter pulses are ignored and reset the filter counter.
  - A rising edge is a 0→1 change of the filtered level.
- **FSM:** states IDLE and GATE.
  - IDLE is entered from reset and lasts exactly 1 cycle. It clears the gate counter and edge counter, then moves to GATE.
  - GATE: the gate counter runs 0..GATE_CYCLES-1 and then wraps. GATE never returns to IDLE except through reset.
- **Edge counter:** 6 bits, saturating at 63.
  - An edge accepted in the terminal cycle (gate counter = GATE_CYCLES-1) counts toward the window that is ending.
  - The counter restarts at 0 for the next window.
- **Window close:**
  - rate_val = min(count, 31).
  - lost = (count == 0).
  - stable = (count == previous window's count); the previous-count register starts at 0 after reset.
  - Compare stable using the saturated 5-bit value.
- **Display:**
  - tens = rate_val / 10 (0–3); units = rate_val % 10.
  - A scan counter alternates pos between 4'b0001 (units) and 4'b0010 (tens) every SCAN_CYCLES.
  - seg shows the digit matching the current pos. The leading tens digit is shown as 0, not blanked.
- Reset mid-operation discards the current window entirely.

## Timing
- **Reset values:**
  - rate_val = 0, rate_vld = 0, stable = 0, lost = 0.
  - pos = 4'b0001, seg = 8'h3F.
  - Filtered level = 0; all counters = 0.
- **Input latency:** sig_in change → filtered edge = 2 sync cycles + FILT_CYCLES.
- **Window close:** in the cycle after the terminal gate cycle, rate_val, lost and stable are registered and rate_vld is high for exactly 1 cycle.
- **First valid result:** the first rate_vld occurs 1 (IDLE) + GATE_CYCLES + 1 cycles after rst_n deasserts. Later results follow every GATE_CYCLES cycles.
- **Display:** seg/pos are registered and update together. A new rate_val is visible at the next digit switch, at most SCAN_CYCLES later.

## Structure
- **Package blink_dec_pkg:**
  - digit pattern constants, 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F;
  - POS_UNITS / POS_TENS;
  - state enum {IDLE, GATE};
  - RATE_MAX = 31.
- **One sub-module, seg_digit_enc:** purely combinational 4-bit digit → 8-bit pattern; digits 10–15 give 8'h00.
- Synchronizer, filter, gate FSM and scan counter live in the top module.

## Test plan
All scenarios use GATE_CYCLES=1000, FILT_CYCLES=4, SCAN_CYCLES=8.
1. Square wave, period 100 cycles, running from reset → every window from the second onward: rate_val=10, rate_vld pulses every 1000 cycles, stable=1, lost=0; tens shows 8'h06, units shows 8'h3F.
2. sig_in held low → each rate_vld shows rate_val=0 and lost=1; from the second window, stable=1; both digits show 8'h3F.
3. Period-100 wave with 2-cycle high glitches added in the low phases → glitches are ignored; rate_val stays 10.
4. Period-20 wave (50 edges per window) → rate_val=31 (saturated), tens 8'h4F, units 8'h06, stable=1 from the second window.
5. Period changes from 100 to 50 at a window boundary → next window: rate_val=20, stable=0; the following window: stable=1.
6. rst_n pulsed low at gate counter 500 with the wave running → all outputs return to reset values immediately; the first rate_vld after release arrives exactly 1002 cycles after deassertion.
